// File: rtl/uart_tx_hold_queue.sv
// rtl/uart_tx_hold_queue.sv - baud-gated holding queue between the UART TX FIFO and the TX shifter
//
// Purpose
//    Circular holding queue of DEPTH words. Words are accepted on any cycle
//    through a valid/ready handshake. The head word is released only on a
//    baud tick while the TX FSM enables transfer and the shifter is ready.
//    The queue tracks occupancy, can be flushed synchronously, and reports a
//    sticky underrun when a release is requested while the queue is empty.
//
// Optional feature
//    UART_HOLD_PARITY_EN : when defined, each entry stores WIDTH+1 bits. Bit
//    WIDTH holds the even parity of the data word, computed at push time.
//    out_data_o is then WIDTH+1 bits wide. When undefined, entries and
//    out_data_o are WIDTH bits and there is no parity logic.
//
// Parameters
//    WIDTH : data word width in bits (>= 1)
//    DEPTH : number of entries (>= 2), need not be a power of two
//
// Ports
//    clk_i       in   system clock, rising edge
//    rst_i       in   asynchronous active-high reset
//    baud_tick_i in   one-cycle strobe from the baud rate generator
//    enable_i    in   TX FSM permits release of the head word
//    clear_i     in   synchronous flush of all entries and of the underrun flag
//    in_valid_i  in   write request from the TX FIFO side
//    in_data_i   in   write data
//    in_ready_o  out  queue can accept a word this cycle
//    out_ready_i in   TX shifter can take the head word
//    out_valid_o out  head word present
//    out_data_o  out  head word, zero when empty
//    count_o     out  current occupancy, 0..DEPTH
//    underrun_o  out  sticky: release requested while empty

module uart_tx_hold_queue #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
`ifdef UART_HOLD_PARITY_EN
   localparam int DW = WIDTH + 1,
`else
   localparam int DW = WIDTH,
`endif
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             baud_tick_i,
   input  logic             enable_i,
   input  logic             clear_i,
   input  logic             in_valid_i,
   input  logic [WIDTH-1:0] in_data_i,
   output logic             in_ready_o,
   input  logic             out_ready_i,
   output logic             out_valid_o,
   output logic [DW-1:0]    out_data_o,
   output logic [CW-1:0]    count_o,
   output logic             underrun_o
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   // Storage has no reset: its contents are meaningless until written, and
   // out_data_o is forced to zero whenever the queue is empty.
   logic [DW-1:0] r_mem [DEPTH];

   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_underrun;

   logic          w_empty;
   logic          w_full;
   logic          w_pop_req;
   logic          w_push;
   logic          w_pop;
   logic [PW-1:0] w_wr_ptr_nxt;
   logic [PW-1:0] w_rd_ptr_nxt;
   logic [DW-1:0] w_wr_word;

   // ------------------------------------------------------------------
   // Status and handshake
   // ------------------------------------------------------------------
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == FULL_CNT);

   // in_ready_o depends on registered occupancy only, so a pop in the same
   // cycle never opens the door for a push into a full queue.
   assign in_ready_o  = ~w_full;
   assign out_valid_o = ~w_empty;
   assign count_o     = r_count;
   assign underrun_o  = r_underrun;

   // A release request exists whenever the tick, the FSM and the shifter
   // agree; it only becomes a real pop if there is a head word to give.
   assign w_pop_req = baud_tick_i & enable_i & out_ready_i;
   assign w_push    = in_valid_i & ~w_full;
   assign w_pop     = w_pop_req & ~w_empty;

   // Explicit wrap so non-power-of-two depths work without masking.
   assign w_wr_ptr_nxt = (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + PW'(1);
   assign w_rd_ptr_nxt = (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + PW'(1);

`ifdef UART_HOLD_PARITY_EN
   // Even parity bit sits above the data so the shifter can send it last.
   assign w_wr_word = {^in_data_i, in_data_i};
`else
   assign w_wr_word = in_data_i;
`endif

   assign out_data_o = w_empty ? '0 : r_mem[r_rd_ptr];

   // ------------------------------------------------------------------
   // Storage write port
   // ------------------------------------------------------------------
   // A flush in the same cycle drops the incoming word, so it is not stored.
   always_ff @(posedge clk_i) begin
      if (w_push && !clear_i) begin
         r_mem[r_wr_ptr] <= w_wr_word;
      end
   end

   // ------------------------------------------------------------------
   // Pointers and occupancy
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= w_wr_ptr_nxt;
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_ptr_nxt;
         end
         // Push and pop together leave the occupancy unchanged.
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Sticky underrun flag
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_underrun <= 1'b0;
      end else if (clear_i) begin
         r_underrun <= 1'b0;
      end else if (w_pop_req && w_empty) begin
         r_underrun <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_hold_queue.sv
// tb/tb_uart_tx_hold_queue.sv - self-checking bench for uart_tx_hold_queue (DEPTH 4 and DEPTH 3 instances)

module tb_uart_tx_hold_queue;

`ifdef UART_HOLD_PARITY_EN
   localparam int OW = 13;
   localparam logic [OW-1:0] EXP_007 = 13'h1007;
   localparam logic [OW-1:0] EXP_003 = 13'h0003;
`else
   localparam int OW = 12;
   localparam logic [OW-1:0] EXP_007 = 12'h007;
   localparam logic [OW-1:0] EXP_003 = 12'h003;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          tick = 1'b0;
   logic          en = 1'b0;
   logic          clr = 1'b0;
   logic          iv = 1'b0;
   logic [11:0]   din = '0;
   logic          ordy = 1'b1;

   logic          o4_ready, o4_valid, o4_und;
   logic [OW-1:0] o4_data;
   logic [2:0]    o4_count;
   logic          o3_ready, o3_valid, o3_und;
   logic [OW-1:0] o3_data;
   logic [1:0]    o3_count;

   int checks = 0;
   int errors = 0;

   // Reference model: plain queues of expected words plus underrun flags.
   logic [OW-1:0] q4[$];
   logic [OW-1:0] q3[$];
   bit            m4_und = 1'b0;
   bit            m3_und = 1'b0;

   always #5 clk = ~clk;

   uart_tx_hold_queue #(.WIDTH(12), .DEPTH(4)) u4 (
      .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .enable_i(en), .clear_i(clr),
      .in_valid_i(iv), .in_data_i(din), .in_ready_o(o4_ready), .out_ready_i(ordy),
      .out_valid_o(o4_valid), .out_data_o(o4_data), .count_o(o4_count), .underrun_o(o4_und)
   );

   uart_tx_hold_queue #(.WIDTH(12), .DEPTH(3)) u3 (
      .clk_i(clk), .rst_i(rst), .baud_tick_i(tick), .enable_i(en), .clear_i(clr),
      .in_valid_i(iv), .in_data_i(din), .in_ready_o(o3_ready), .out_ready_i(ordy),
      .out_valid_o(o3_valid), .out_data_o(o3_data), .count_o(o3_count), .underrun_o(o3_und)
   );

   function automatic logic [OW-1:0] enc(input logic [11:0] d);
`ifdef UART_HOLD_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Apply the queue rules to the model for the inputs present at this edge.
   task automatic model_upd();
      bit try_pop;
      bit pu4, po4, pu3, po3;
      try_pop = tick & en & ordy;
      if (clr) begin
         q4.delete(); q3.delete();
         m4_und = 1'b0; m3_und = 1'b0;
      end else begin
         pu4 = iv && (q4.size() < 4);
         po4 = try_pop && (q4.size() > 0);
         if (try_pop && q4.size() == 0) m4_und = 1'b1;
         if (po4) void'(q4.pop_front());
         if (pu4) q4.push_back(enc(din));
         pu3 = iv && (q3.size() < 3);
         po3 = try_pop && (q3.size() > 0);
         if (try_pop && q3.size() == 0) m3_und = 1'b1;
         if (po3) void'(q3.pop_front());
         if (pu3) q3.push_back(enc(din));
      end
   endtask

   // One clock cycle with the given inputs; returns 2 time units after the edge.
   task automatic step(input bit s_iv, input logic [11:0] s_d, input bit s_tick,
                       input bit s_en, input bit s_clr);
      iv = s_iv; din = s_d; tick = s_tick; en = s_en; clr = s_clr;
      @(posedge clk);
      model_upd();
      #2;
      iv = 1'b0; tick = 1'b0; clr = 1'b0;
   endtask

   task automatic push(input logic [11:0] d);
      step(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic pop();
      step(1'b0, 12'h000, 1'b1, 1'b1, 1'b0);
   endtask

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clk) begin
      if (!rst) begin
         chk("valid4", o4_valid, q4.size() != 0);
         chk("data4",  o4_data,  (q4.size() != 0) ? q4[0] : '0);
         chk("count4", o4_count, q4.size());
         chk("ready4", o4_ready, q4.size() < 4);
         chk("under4", o4_und,   m4_und);
         chk("valid3", o3_valid, q3.size() != 0);
         chk("data3",  o3_data,  (q3.size() != 0) ? q3[0] : '0);
         chk("count3", o3_count, q3.size());
         chk("ready3", o3_ready, q3.size() < 3);
         chk("under3", o3_und,   m3_und);
      end
   end

   initial begin
      // Power-on reset
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      chk("rst_count", o4_count, 0);
      chk("rst_valid", o4_valid, 0);
      chk("rst_ready", o4_ready, 1);
      chk("rst_data",  o4_data,  0);
      chk("rst_under", o4_und,   0);

      // Fill and drain
      push(12'h001); push(12'h002); push(12'h003); push(12'h004);
      chk("fill_count", o4_count, 4);
      chk("fill_ready", o4_ready, 0);
      chk("fill_head",  o4_data,  12'h001);
      chk("fill3_count", o3_count, 3);
      pop(); chk("drain_1", o4_data, 12'h002);
      pop(); chk("drain_2", o4_data, 12'h003);
      pop(); chk("drain_3", o4_data, 12'h004);
      pop(); chk("drain_end", o4_count, 0);
      chk("drain3_under", o3_und, 1);
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);

      // Hold while disabled
      push(12'h0A5);
      for (int i = 0; i < 10; i++) begin
         step(1'b0, 12'h000, 1'b1, 1'b0, 1'b0);
         chk("hold_data",  o4_data,  12'h0A5);
         chk("hold_count", o4_count, 1);
      end
      pop();
      chk("hold_pop", o4_count, 0);

      // Full queue: simultaneous tick and push
      push(12'h011); push(12'h012); push(12'h013); push(12'h014);
      step(1'b1, 12'h015, 1'b1, 1'b1, 1'b0);
      chk("full_pp_count", o4_count, 3);
      chk("full_pp_head",  o4_data,  12'h012);
      push(12'h015);
      chk("full_refill", o4_count, 4);
      repeat (4) pop();

      // Asynchronous reset mid-run with a pending tick and push
      push(12'h021); push(12'h022); push(12'h023);
      chk("pre_rst_count", o4_count, 3);
      iv = 1'b1; din = 12'h024; tick = 1'b1; en = 1'b1;
      #1 rst = 1'b1;
      q4.delete(); q3.delete(); m4_und = 1'b0; m3_und = 1'b0;
      #1;
      chk("arst_valid", o4_valid, 0);
      chk("arst_count", o4_count, 0);
      chk("arst_ready", o4_ready, 1);
      chk("arst_under", o4_und,   0);
      iv = 1'b0; tick = 1'b0; en = 1'b0;
      @(posedge clk);
      #2 rst = 1'b0;

      // Wrap-around through push/pop pairs, then underrun
      push(12'h100);
      for (int i = 1; i < 7; i++) begin
         step(1'b1, 12'(12'h100 + i), 1'b1, 1'b1, 1'b0);
         chk("wrap_head3", o3_data, 12'h100 + i);
         chk("wrap_count3", o3_count, 1);
      end
      pop();
      chk("wrap_empty3", o3_count, 0);
      chk("wrap_no_under", o3_und, 0);
      pop();
      chk("under_set3", o3_und, 1);
      chk("under_set4", o4_und, 1);
      repeat (3) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);
      chk("under_sticky", o3_und, 1);
      step(1'b0, 12'h000, 1'b0, 1'b0, 1'b1);
      chk("under_clear", o3_und, 0);

      // Stored word format, and flush dropping an in-flight push
      push(12'h007);
      chk("word_007", o4_data, EXP_007);
      pop();
      push(12'h003);
      chk("word_003", o4_data, EXP_003);
      step(1'b1, 12'h055, 1'b0, 1'b0, 1'b1);
      chk("clr_push_count", o4_count, 0);
      chk("clr_push_valid", o4_valid, 0);
      repeat (2) step(1'b0, 12'h000, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
